conv_window_sched: RTL and testbench
====================================

# conv_window_sched

Sequencing controller for the row-serial convolution datapath. It walks every output position of one layer pass, and for each window:
- clears the dot-product engine;
- streams KERNEL_SIZE row beats (input row and column coordinates plus the kernel row) into the engine under a valid/ready handshake;
- waits for the engine result and writes it to the result buffer with backpressure.

It sits between the layer top (start/done) and the engine plus the input/kernel/result buffers. It replaces the ad-hoc stride bookkeeping in the layer top.

## Interface
Parameters:
- INPUT_DIM, 28, input feature map side length
- KERNEL_SIZE, 21, kernel side length (1 ≤ KERNEL_SIZE ≤ INPUT_DIM)
- STRIDE, 7, window step in rows and columns (≥ 1)
- OUTBITWIDTH, 25, engine result width
- OUTPUT_DIM, (INPUT_DIM-KERNEL_SIZE)/STRIDE+1, output side length (derived)
- IDX_W, $clog2(INPUT_DIM), width of input row/column indices
- KIDX_W, $clog2(KERNEL_SIZE) (minimum 1), width of the kernel row index
- OADDR_W, $clog2(OUTPUT_DIM*OUTPUT_DIM) (minimum 1), width of the result address

Ports (clock and reset):
- clk in 1: clock
- reset in 1: synchronous, active-high

Layer control:
- start in 1: begins a pass when sampled in IDLE
- busy out 1: high from the cycle after start is accepted until DONE
- done out 1: one-cycle pulse at end of pass

Engine:
- eng_clear out 1: one-cycle accumulator clear pulse before each window
- row_valid out 1: row beat valid
- row_ready in 1: engine accepts the beat
- in_row out IDX_W: input buffer row, out_r*STRIDE+k
- in_col out IDX_W: input buffer starting column, out_c*STRIDE
- ker_row out KIDX_W: kernel row k
- row_last out 1: beat is k==KERNEL_SIZE-1
- eng_done in 1: engine result valid (single-cycle pulse)
- eng_result in OUTBITWIDTH: engine result

Result buffer:
- res_we out 1: write request
- res_ready in 1: buffer accepts the write
- res_addr out OADDR_W: out_r*OUTPUT_DIM+out_c
- res_data out OUTBITWIDTH: captured result

## Operation
- Internal counters:
  - out_r, out_c in 0..OUTPUT_DIM-1: row-major, column fastest.
  - k in 0..KERNEL_SIZE-1.
- States and transitions:
  - IDLE: start → CLEAR; out_r, out_c cleared. start while not in IDLE is ignored.
  - CLEAR: eng_clear=1 for exactly one cycle; k←0; → ISSUE.
  - ISSUE: row_valid=1; outputs hold stable until the handshake. On row_valid&row_ready: if row_last → WAIT, else k←k+1.
  - WAIT: on eng_done: res_data←eng_result → WRITE.
  - WRITE: res_we=1, res_addr/res_data held until res_ready. On handshake:
    - last position (out_r=out_c=OUTPUT_DIM-1) → DONE;
    - else if out_c=OUTPUT_DIM-1 → out_c←0, out_r←out_r+1, → CLEAR;
    - else out_c←out_c+1 → CLEAR.
  - DONE: done=1, busy=0 → IDLE.
- eng_done outside WAIT is ignored; it neither captures data nor changes state.
- in_row/in_col are computed from counters; in_row must never exceed INPUT_DIM-1 for legal parameters.
- All address/index arithmetic is unsigned. Products are sized to avoid truncation before assignment to IDX_W/OADDR_W.

## Timing
- Reset (any state, including mid-pass) returns to IDLE next edge. Outputs become 0: busy, done, eng_clear, row_valid, row_last, in_row, in_col, ker_row, res_we, res_addr, res_data. Counters are cleared. No partial write completes after reset.
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.
- start sampled at edge 0: CLEAR is cycle 1 and busy=1 from cycle 1.
- Per window with row_ready=1, eng_done in the first WAIT cycle and res_ready=1: 1 (CLEAR) + KERNEL_SIZE (ISSUE) + 1 (WAIT) + 1 (WRITE) = KERNEL_SIZE+3 cycles.
- Pass length under those conditions: OUTPUT_DIM²·(KERNEL_SIZE+3) cycles, then done in the next cycle.
- Stalls (row_ready=0, late eng_done, res_ready=0) extend the current state only; no beat is dropped or repeated.
- If OUTPUT_DIM=1, exactly one window runs.

## Test plan
- Default params, row_ready=res_ready=1, eng_done one cycle after the last beat, eng_result=window index+100:
  - 4 writes, addr 0,1,2,3, data 100..103;
  - in_col 0,7,0,7; first in_row of each window 0,0,7,7;
  - done in cycle 97 after start.
- row_ready toggled 0/1 every cycle: each window shows 21 accepted beats with ker_row 0..20 in order and row_last only on ker_row=20; outputs stable while row_ready=0.
- res_ready held 0 for 5 cycles on the second write: res_we, res_addr=1, res_data held for 5 cycles; the next eng_clear occurs only after acceptance.
- eng_done pulsed during ISSUE and during IDLE: no state change, no write. start pulsed mid-pass: ignored, pass completes with 4 writes.
- reset asserted in ISSUE of window 2: next cycle all outputs 0, state IDLE. A following start produces a full 4-write pass from addr 0.
- INPUT_DIM=5, KERNEL_SIZE=3, STRIDE=1: 9 writes, addr 0..8, in_row/in_col window origins covering 0..2 each, done after 9·6+1 cycles.

Source files
------------

// File: rtl/conv_window_sched.sv
// Window sequencer for the row-serial convolution engine: walks every output
// position, streams the kernel rows of each window and writes back the result.
module conv_window_sched #(
  parameter int INPUT_DIM   = 28,
  parameter int KERNEL_SIZE = 21,
  parameter int STRIDE      = 7,
  parameter int OUTBITWIDTH = 25,
  parameter int OUTPUT_DIM  = (INPUT_DIM - KERNEL_SIZE) / STRIDE + 1,
  parameter int IDX_W       = (INPUT_DIM > 1) ? $clog2(INPUT_DIM) : 1,
  parameter int KIDX_W      = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1,
  parameter int OADDR_W     = (OUTPUT_DIM > 1) ? $clog2(OUTPUT_DIM * OUTPUT_DIM) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   eng_clear,
  output logic                   row_valid,
  input  logic                   row_ready,
  output logic [IDX_W-1:0]       in_row,
  output logic [IDX_W-1:0]       in_col,
  output logic [KIDX_W-1:0]      ker_row,
  output logic                   row_last,
  input  logic                   eng_done,
  input  logic [OUTBITWIDTH-1:0] eng_result,
  output logic                   res_we,
  input  logic                   res_ready,
  output logic [OADDR_W-1:0]     res_addr,
  output logic [OUTBITWIDTH-1:0] res_data,
  output logic [2:0]             dbg_state
);

  // Handshakes: a row beat transfers on a rising edge where row_valid and
  // row_ready are both high; a result write transfers where res_we and
  // res_ready are both high. Valid-side outputs hold steady until transfer.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0]  OMAX     = IDX_W'(OUTPUT_DIM - 1);
  localparam logic [KIDX_W-1:0] KMAX     = KIDX_W'(KERNEL_SIZE - 1);
  localparam logic [31:0]       STRIDE_U = 32'(STRIDE);
  localparam logic [31:0]       ODIM_U   = 32'(OUTPUT_DIM);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       out_r_q, out_r_d;
  logic [IDX_W-1:0]       out_c_q, out_c_d;
  logic [KIDX_W-1:0]      k_q, k_d;
  logic [OUTBITWIDTH-1:0] res_data_q, res_data_d;

  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   eng_clear_q, eng_clear_d;
  logic                   row_valid_q, row_valid_d;
  logic                   row_last_q, row_last_d;
  logic [IDX_W-1:0]       in_row_q, in_row_d;
  logic [IDX_W-1:0]       in_col_q, in_col_d;
  logic [KIDX_W-1:0]      ker_row_q, ker_row_d;
  logic                   res_we_q, res_we_d;
  logic [OADDR_W-1:0]     res_addr_q, res_addr_d;

  always_comb begin
    state_d    = state_q;
    out_r_d    = out_r_q;
    out_c_d    = out_c_q;
    k_d        = k_q;
    res_data_d = res_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          out_r_d = '0;
          out_c_d = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        k_d     = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (row_valid_q && row_ready) begin
          if (k_q == KMAX) state_d = S_WAIT;
          else             k_d     = k_q + KIDX_W'(1);
        end
      end
      S_WAIT: begin
        if (eng_done) begin
          res_data_d = eng_result;
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        if (res_we_q && res_ready) begin
          if (out_r_q == OMAX && out_c_q == OMAX) begin
            state_d = S_DONE;
          end else if (out_c_q == OMAX) begin
            out_c_d = '0;
            out_r_d = out_r_q + IDX_W'(1);
            state_d = S_CLEAR;
          end else begin
            out_c_d = out_c_q + IDX_W'(1);
            state_d = S_CLEAR;
          end
        end
      end
      S_DONE: begin
        out_r_d = '0;
        out_c_d = '0;
        k_d     = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so that the registered copies
  // line up with state_q without any input-to-output combinational path.
  always_comb begin
    busy_d      = (state_d == S_CLEAR) || (state_d == S_ISSUE) ||
                  (state_d == S_WAIT)  || (state_d == S_WRITE);
    done_d      = (state_d == S_DONE);
    eng_clear_d = (state_d == S_CLEAR);
    row_valid_d = (state_d == S_ISSUE);
    row_last_d  = (state_d == S_ISSUE) && (k_d == KMAX);
    res_we_d    = (state_d == S_WRITE);
    in_row_d    = IDX_W'(32'(out_r_d) * STRIDE_U + 32'(k_d));
    in_col_d    = IDX_W'(32'(out_c_d) * STRIDE_U);
    ker_row_d   = k_d;
    res_addr_d  = OADDR_W'(32'(out_r_d) * ODIM_U + 32'(out_c_d));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_r_q     <= '0;
      out_c_q     <= '0;
      k_q         <= '0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      eng_clear_q <= 1'b0;
      row_valid_q <= 1'b0;
      row_last_q  <= 1'b0;
      in_row_q    <= '0;
      in_col_q    <= '0;
      ker_row_q   <= '0;
      res_we_q    <= 1'b0;
      res_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_r_q     <= out_r_d;
      out_c_q     <= out_c_d;
      k_q         <= k_d;
      res_data_q  <= res_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      eng_clear_q <= eng_clear_d;
      row_valid_q <= row_valid_d;
      row_last_q  <= row_last_d;
      in_row_q    <= in_row_d;
      in_col_q    <= in_col_d;
      ker_row_q   <= ker_row_d;
      res_we_q    <= res_we_d;
      res_addr_q  <= res_addr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign eng_clear = eng_clear_q;
  assign row_valid = row_valid_q;
  assign row_last  = row_last_q;
  assign in_row    = in_row_q;
  assign in_col    = in_col_q;
  assign ker_row   = ker_row_q;
  assign res_we    = res_we_q;
  assign res_addr  = res_addr_q;
  assign res_data  = res_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_window_sched.sv
// Bench for conv_window_sched: two instances (default and 5/3/1 geometry)
// driven by one engine/buffer responder and checked against a window model.
module tb_conv_window_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        row_ready = 1'b1, eng_done = 1'b0, res_ready = 1'b1;
  logic [24:0] eng_result = '0;

  logic       a_busy, a_done, a_eng_clear, a_row_valid, a_row_last, a_res_we;
  logic [4:0] a_in_row, a_in_col, a_ker_row;
  logic [1:0] a_res_addr;
  logic [24:0] a_res_data;
  logic [2:0] a_dbg;

  logic       b_busy, b_done, b_eng_clear, b_row_valid, b_row_last, b_res_we;
  logic [2:0] b_in_row, b_in_col;
  logic [1:0] b_ker_row;
  logic [3:0] b_res_addr;
  logic [24:0] b_res_data;
  logic [2:0] b_dbg;

  always #5 clk = ~clk;

  conv_window_sched #(.INPUT_DIM(28), .KERNEL_SIZE(21), .STRIDE(7), .OUTBITWIDTH(25)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(a_busy), .done(a_done),
    .eng_clear(a_eng_clear), .row_valid(a_row_valid), .row_ready(row_ready),
    .in_row(a_in_row), .in_col(a_in_col), .ker_row(a_ker_row), .row_last(a_row_last),
    .eng_done(eng_done), .eng_result(eng_result), .res_we(a_res_we), .res_ready(res_ready),
    .res_addr(a_res_addr), .res_data(a_res_data), .dbg_state(a_dbg));

  conv_window_sched #(.INPUT_DIM(5), .KERNEL_SIZE(3), .STRIDE(1), .OUTBITWIDTH(25)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(b_busy), .done(b_done),
    .eng_clear(b_eng_clear), .row_valid(b_row_valid), .row_ready(row_ready),
    .in_row(b_in_row), .in_col(b_in_col), .ker_row(b_ker_row), .row_last(b_row_last),
    .eng_done(eng_done), .eng_result(eng_result), .res_we(b_res_we), .res_ready(res_ready),
    .res_addr(b_res_addr), .res_data(b_res_data), .dbg_state(b_dbg));

  int sel = 0;
  int m_busy, m_done, m_clear, m_rv, m_last, m_we, m_row, m_col, m_kr, m_addr, m_dbg;
  longint m_data;
  assign m_busy  = (sel != 0) ? int'(b_busy)      : int'(a_busy);
  assign m_done  = (sel != 0) ? int'(b_done)      : int'(a_done);
  assign m_clear = (sel != 0) ? int'(b_eng_clear) : int'(a_eng_clear);
  assign m_rv    = (sel != 0) ? int'(b_row_valid) : int'(a_row_valid);
  assign m_last  = (sel != 0) ? int'(b_row_last)  : int'(a_row_last);
  assign m_we    = (sel != 0) ? int'(b_res_we)    : int'(a_res_we);
  assign m_row   = (sel != 0) ? int'(b_in_row)    : int'(a_in_row);
  assign m_col   = (sel != 0) ? int'(b_in_col)    : int'(a_in_col);
  assign m_kr    = (sel != 0) ? int'(b_ker_row)   : int'(a_ker_row);
  assign m_addr  = (sel != 0) ? int'(b_res_addr)  : int'(a_res_addr);
  assign m_dbg   = (sel != 0) ? int'(b_dbg)       : int'(a_dbg);
  assign m_data  = (sel != 0) ? longint'(b_res_data) : longint'(a_res_data);

  typedef struct { int row; int col; int kr; int last; } beat_t;
  typedef struct {
    int sel; int rr_mode; int rand_mode; int stray; int stall_idx; int stall_len;
    int mid_start; int exp_len;
  } pass_vec_t;

  beat_t       exp_beat_q[$];
  logic [31:0] exp_addr_q[$];
  logic [24:0] exp_data_q[$];

  int checks = 0, errors = 0, cyc = 0;
  int rr_mode = 0, rand_mode = 0, stray_en = 0, stall_idx = -1, stall_left = 0;
  int start_req = 0, reset_req = 0;
  int eng_pending = 0, eng_wait = 0, win = 0, wr_idx = 0, clear_cnt = 0, we_hold_cnt = 0;
  int prev_rv_stall = 0, prev_we_stall = 0;
  int p_row, p_col, p_kr, p_last, p_addr;
  longint p_data;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: every window in row-major order, KERNEL_SIZE beats each.
  task automatic model_pass(input int idim, input int ks, input int st, output int windows);
    int od;
    od = (idim - ks) / st + 1;
    windows = od * od;
    for (int w = 0; w < od * od; w++) begin
      exp_addr_q.push_back(32'(w));
      for (int k = 0; k < ks; k++)
        exp_beat_q.push_back('{(w / od) * st + k, (w % od) * st, k, (k == ks - 1) ? 1 : 0});
    end
  endtask

  task automatic clear_sb();
    exp_beat_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
    eng_pending = 0; eng_wait = 0; win = 0; wr_idx = 0; clear_cnt = 0; we_hold_cnt = 0;
    prev_rv_stall = 0; prev_we_stall = 0; stall_left = 0;
  endtask

  // One cycle: observe outputs at the falling edge, choose inputs for the
  // next rising edge, then score any transfer that edge will complete.
  task automatic tick();
    beat_t b;
    @(negedge clk);
    cyc++;
    if (prev_rv_stall != 0) begin
      chk("row_hold_valid", m_rv, 1);
      chk("row_hold_row", m_row, p_row);
      chk("row_hold_col", m_col, p_col);
      chk("row_hold_kr", m_kr, p_kr);
      chk("row_hold_last", m_last, p_last);
    end
    if (prev_we_stall != 0) begin
      chk("wr_hold_we", m_we, 1);
      chk("wr_hold_addr", m_addr, p_addr);
      chk("wr_hold_data", m_data, p_data);
    end
    if (m_clear != 0) clear_cnt++;
    if (m_we != 0 && wr_idx == stall_idx) we_hold_cnt++;

    start_a = (start_req != 0 && sel == 0);
    start_b = (start_req != 0 && sel != 0);
    start_req = 0;
    reset = (reset_req != 0);
    reset_req = 0;
    case (rr_mode)
      0:       row_ready = 1'b1;
      1:       row_ready = ~row_ready;
      default: row_ready = 1'($urandom_range(0, 1));
    endcase
    if (stall_left > 0 && m_we != 0 && wr_idx == stall_idx) begin
      res_ready = 1'b0;
      stall_left--;
    end else if (rand_mode != 0) res_ready = 1'($urandom_range(0, 1));
    else res_ready = 1'b1;
    eng_done = 1'b0;
    if (eng_pending != 0) begin
      if (eng_wait == 0) begin
        eng_done = 1'b1;
        eng_result = (rand_mode != 0) ? 25'($urandom) : 25'(win + 100);
        exp_data_q.push_back(eng_result);
        win++;
        eng_pending = 0;
      end else eng_wait--;
    end else if (stray_en != 0 && $urandom_range(0, 5) == 0) begin
      eng_done = 1'b1;
      eng_result = 25'($urandom);
    end

    if (!reset) begin
      if (m_rv != 0 && row_ready) begin
        if (exp_beat_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          b = exp_beat_q.pop_front();
          chk("beat_in_row", m_row, b.row);
          chk("beat_in_col", m_col, b.col);
          chk("beat_ker_row", m_kr, b.kr);
          chk("beat_row_last", m_last, b.last);
        end
        if (m_last != 0) begin
          eng_pending = 1;
          eng_wait = (rand_mode != 0) ? int'($urandom_range(0, 3)) : 0;
        end
      end
      if (m_we != 0 && res_ready) begin
        if (exp_addr_q.size() == 0 || exp_data_q.size() == 0) chk("extra_write", 1, 0);
        else begin
          chk("wr_addr", m_addr, longint'(exp_addr_q.pop_front()));
          chk("wr_data", m_data, longint'(exp_data_q.pop_front()));
        end
        wr_idx++;
      end
    end
    prev_rv_stall = (!reset && m_rv != 0 && !row_ready) ? 1 : 0;
    prev_we_stall = (!reset && m_we != 0 && !res_ready) ? 1 : 0;
    p_row = m_row; p_col = m_col; p_kr = m_kr; p_last = m_last;
    p_addr = m_addr; p_data = m_data;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_state"}, m_dbg, 0);
    chk({tag, "_busy"}, m_busy, 0);
    chk({tag, "_done"}, m_done, 0);
    chk({tag, "_clear"}, m_clear, 0);
    chk({tag, "_row_valid"}, m_rv, 0);
    chk({tag, "_row_last"}, m_last, 0);
    chk({tag, "_in_row"}, m_row, 0);
    chk({tag, "_in_col"}, m_col, 0);
    chk({tag, "_ker_row"}, m_kr, 0);
    chk({tag, "_res_we"}, m_we, 0);
    chk({tag, "_res_addr"}, m_addr, 0);
    chk({tag, "_res_data"}, m_data, 0);
  endtask

  task automatic run_pass(input pass_vec_t v);
    int windows, n, got_done;
    clear_sb();
    sel = v.sel; rr_mode = v.rr_mode; rand_mode = v.rand_mode; stray_en = v.stray;
    stall_idx = v.stall_idx; stall_left = v.stall_len;
    if (v.sel != 0) model_pass(5, 3, 1, windows);
    else            model_pass(28, 21, 7, windows);
    start_req = 1;
    tick();
    n = 0; got_done = 0;
    while (got_done == 0 && n < 5000) begin
      if (v.mid_start != 0 && n == 30) start_req = 1;
      tick();
      n++;
      if (n == 1) begin
        chk("busy_cycle1", m_busy, 1);
        chk("clear_cycle1", m_clear, 1);
      end
      if (m_done != 0) begin
        got_done = 1;
        chk("busy_at_done", m_busy, 0);
      end
    end
    chk("done_seen", got_done, 1);
    if (v.exp_len >= 0) chk("pass_length", n, v.exp_len);
    chk("writes", wr_idx, windows);
    chk("clears", clear_cnt, windows);
    chk("beats_left", exp_beat_q.size(), 0);
    chk("addr_left", exp_addr_q.size(), 0);
    if (v.stall_len > 0) chk("stall_we_cycles", we_hold_cnt, v.stall_len + 1);
    tick();
    chk("idle_after_done", m_dbg, 0);
    chk("done_one_cycle", m_done, 0);
    stray_en = 0;
  endtask

  pass_vec_t tbl[7];
  int n;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 0, 0, 0, -1, 0, 0, 97};
    tbl[1] = '{0, 1, 0, 0, -1, 0, 0, -1};
    tbl[2] = '{0, 0, 0, 0, 1, 5, 0, 102};
    tbl[3] = '{0, 0, 0, 1, -1, 0, 1, 97};
    tbl[4] = '{1, 0, 0, 0, -1, 0, 0, 55};
    tbl[5] = '{0, 2, 1, 1, -1, 0, 0, -1};
    tbl[6] = '{1, 2, 1, 1, -1, 0, 0, -1};

    reset_req = 1; tick();
    reset_req = 1; tick();
    tick();
    sel = 0; check_zero_outputs("reset_a");
    sel = 1; check_zero_outputs("reset_b");

    // Stray engine pulses while idle must not move either instance.
    sel = 0; clear_sb(); stray_en = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("idle_stray_state", m_dbg, 0);
      chk("idle_stray_we", m_we, 0);
    end
    stray_en = 0;
    tick();

    for (int i = 0; i < 7; i++) run_pass(tbl[i]);

    // Reset during the second window's row issue, then a clean pass.
    clear_sb(); sel = 0; rr_mode = 0; rand_mode = 0; stall_idx = -1;
    begin
      int w;
      model_pass(28, 21, 7, w);
    end
    start_req = 1; tick();
    n = 0;
    while (!(wr_idx == 1 && m_rv != 0) && n < 500) begin tick(); n++; end
    chk("reach_window2_issue", (wr_idx == 1 && m_rv != 0) ? 1 : 0, 1);
    reset_req = 1; tick();
    tick();
    check_zero_outputs("midreset");
    clear_sb();
    run_pass(tbl[0]);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
